// File: rtl/rx_frame_counter.sv
// Receive-path frame sequencer: tracks word position within a frame and generates the
// registered field strobes, end-of-data byte counts and status pulses for the departure stage.
module rx_frame_counter #(
   parameter int unsigned MAX_WORDS = 191,
   parameter int unsigned PAD_REM   = 44
) (
   input  logic        rxclk,
   input  logic        reset,
   input  logic        get_sfd,
   input  logic        get_error_code,
   input  logic        get_terminate,
   input  logic [15:0] lt_data,
   input  logic        small_frame,
   input  logic        tagged_frame,
   input  logic [15:0] tagged_len,
   output logic        start_da,
   output logic        start_lt,
   output logic        receiving,
   output logic        receiving_frame,
   output logic        end_data_cnt,
   output logic [2:0]  bits_more,
   output logic        end_small_cnt,
   output logic [2:0]  small_bits_more,
   output logic        frame_done,
   output logic        frame_abort,
   output logic        too_long
);

   localparam logic [2:0] StIdle = 3'd0;
   localparam logic [2:0] StDa   = 3'd1;
   localparam logic [2:0] StLt   = 3'd2;
   localparam logic [2:0] StData = 3'd3;
   localparam logic [2:0] StFcs  = 3'd4;
   localparam logic [2:0] StDrop = 3'd5;

   localparam logic [15:0] PadRem   = 16'(PAD_REM);
   localparam logic [10:0] MaxWords = 11'(MAX_WORDS);
   localparam logic [15:0] TypeMin  = 16'h05fe;

   logic [2:0]  state_q, state_d;
   logic [15:0] rem_q, rem_d, srem_q, srem_d;
   logic [10:0] wcnt_q, wcnt_d;
   logic        type_q, type_d, tagged_q, tagged_d, first_q, first_d, small_q, small_d;
   logic        start_da_d, start_lt_d, receiving_d, receiving_frame_d;
   logic        end_data_cnt_d, end_small_cnt_d, frame_done_d, frame_abort_d, too_long_d;
   logic [2:0]  bits_more_d, small_bits_more_d;
   logic [15:0] rem_ld, srem_ld, rem_nxt, srem_nxt, tag_rem;
   logic [10:0] wcnt_inc;

   // Counters hold the byte count of the word being presented, so end strobes line up with it.
   always_comb begin
      srem_ld  = lt_data[15] ? 16'd0 : lt_data;
      rem_ld   = small_frame ? PadRem : lt_data;
      tag_rem  = (tagged_len >= 16'd8) ? tagged_len - 16'd8 : 16'd0;
      rem_nxt  = (first_q && tagged_q) ? tag_rem : rem_q - 16'd8;
      srem_nxt = srem_q - 16'd8;
      wcnt_inc = (wcnt_q == 11'h7ff) ? wcnt_q : wcnt_q + 11'd1;
   end

   always_comb begin
      state_d           = state_q;
      rem_d             = rem_q;
      srem_d            = srem_q;
      wcnt_d            = wcnt_q;
      type_d            = type_q;
      tagged_d          = tagged_q;
      small_d           = small_q;
      first_d           = 1'b0;
      start_da_d        = 1'b0;
      start_lt_d        = 1'b0;
      end_data_cnt_d    = 1'b0;
      end_small_cnt_d   = 1'b0;
      frame_done_d      = 1'b0;
      frame_abort_d     = 1'b0;
      too_long_d        = 1'b0;
      receiving_d       = receiving;
      receiving_frame_d = receiving_frame;
      bits_more_d       = bits_more;
      small_bits_more_d = small_bits_more;

      if (get_error_code && (state_q == StDa || state_q == StLt || state_q == StData)) begin
         state_d           = StIdle;
         frame_abort_d     = 1'b1;
         receiving_d       = 1'b0;
         receiving_frame_d = 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (get_sfd) begin
                  state_d           = StDa;
                  start_da_d        = 1'b1;
                  receiving_d       = 1'b1;
                  receiving_frame_d = 1'b1;
                  wcnt_d            = 11'd1;
               end
            end
            StDa: begin
               state_d    = StLt;
               start_lt_d = 1'b1;
               wcnt_d     = wcnt_inc;
            end
            StLt: begin
               state_d  = StData;
               wcnt_d   = wcnt_inc;
               first_d  = 1'b1;
               small_d  = 1'b0;
               tagged_d = 1'b0;
               type_d   = 1'b0;
               rem_d    = rem_ld;
               if (small_frame) begin
                  srem_d = srem_ld;
                  if (srem_ld[15:3] == 13'd0) begin
                     end_small_cnt_d   = 1'b1;
                     small_bits_more_d = srem_ld[2:0];
                  end else begin
                     small_d = 1'b1;
                  end
               end else if (tagged_frame) begin
                  tagged_d = 1'b1;
               end else if (lt_data >= TypeMin) begin
                  type_d = 1'b1;
               end
               if (!tagged_d && !type_d && rem_ld[15:3] == 13'd0) begin
                  end_data_cnt_d = 1'b1;
                  bits_more_d    = rem_ld[2:0];
               end
            end
            StData: begin
               wcnt_d = wcnt_inc;
               if (wcnt_q == MaxWords) begin
                  state_d           = StDrop;
                  too_long_d        = 1'b1;
                  receiving_d       = 1'b0;
                  receiving_frame_d = 1'b0;
               end else if (get_terminate && (type_q || !end_data_cnt)) begin
                  state_d           = StIdle;
                  receiving_d       = 1'b0;
                  receiving_frame_d = 1'b0;
                  frame_done_d      = type_q;
                  frame_abort_d     = !type_q;
               end else if (!type_q) begin
                  if (end_data_cnt) begin
                     state_d     = StFcs;
                     receiving_d = 1'b0;
                  end else begin
                     rem_d = rem_nxt;
                     if (rem_nxt[15:3] == 13'd0) begin
                        end_data_cnt_d = 1'b1;
                        bits_more_d    = rem_nxt[2:0];
                     end
                  end
                  if (small_q) begin
                     srem_d = srem_nxt;
                     if (srem_nxt[15:3] == 13'd0) begin
                        end_small_cnt_d   = 1'b1;
                        small_bits_more_d = srem_nxt[2:0];
                        small_d           = 1'b0;
                     end
                  end
               end
            end
            StFcs: begin
               state_d           = StIdle;
               frame_done_d      = 1'b1;
               receiving_frame_d = 1'b0;
            end
            StDrop: begin
               if (get_terminate) state_d = StIdle;
            end
            default: begin
               state_d           = StIdle;
               receiving_d       = 1'b0;
               receiving_frame_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge rxclk or posedge reset) begin
      if (reset) begin
         state_q         <= StIdle;
         rem_q           <= 16'd0;
         srem_q          <= 16'd0;
         wcnt_q          <= 11'd0;
         type_q          <= 1'b0;
         tagged_q        <= 1'b0;
         small_q         <= 1'b0;
         first_q         <= 1'b0;
         start_da        <= 1'b0;
         start_lt        <= 1'b0;
         receiving       <= 1'b0;
         receiving_frame <= 1'b0;
         end_data_cnt    <= 1'b0;
         bits_more       <= 3'd0;
         end_small_cnt   <= 1'b0;
         small_bits_more <= 3'd0;
         frame_done      <= 1'b0;
         frame_abort     <= 1'b0;
         too_long        <= 1'b0;
      end else begin
         state_q         <= state_d;
         rem_q           <= rem_d;
         srem_q          <= srem_d;
         wcnt_q          <= wcnt_d;
         type_q          <= type_d;
         tagged_q        <= tagged_d;
         small_q         <= small_d;
         first_q         <= first_d;
         start_da        <= start_da_d;
         start_lt        <= start_lt_d;
         receiving       <= receiving_d;
         receiving_frame <= receiving_frame_d;
         end_data_cnt    <= end_data_cnt_d;
         bits_more       <= bits_more_d;
         end_small_cnt   <= end_small_cnt_d;
         small_bits_more <= small_bits_more_d;
         frame_done      <= frame_done_d;
         frame_abort     <= frame_abort_d;
         too_long        <= too_long_d;
      end
   end

endmodule

// File: tb/tb_rx_frame_counter.sv
// Bench for rx_frame_counter: directed and random frames against a word-index model, run on a
// default instance and on a short-jabber instance sharing the same stimulus.
module tb_rx_frame_counter;

   typedef struct packed {
      logic       sda;
      logic       slt;
      logic       rcv;
      logic       rfr;
      logic       edc;
      logic [2:0] bm;
      logic       esc;
      logic [2:0] sbm;
      logic       fd;
      logic       fa;
      logic       tl;
   } out_t;

   localparam int KLen   = 0;
   localparam int KSmall = 1;
   localparam int KTag   = 2;
   localparam int KType  = 3;
   localparam int Pad    = 44;
   localparam int MaxM   = 191;
   localparam int MaxJ   = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        get_sfd, get_error_code, get_terminate, small_frame, tagged_frame;
   logic [15:0] lt_data, tagged_len;

   logic       m_sda, m_slt, m_rcv, m_rfr, m_edc, m_esc, m_fd, m_fa, m_tl;
   logic [2:0] m_bm, m_sbm;
   logic       j_sda, j_slt, j_rcv, j_rfr, j_edc, j_esc, j_fd, j_fa, j_tl;
   logic [2:0] j_bm, j_sbm;
   out_t       obs_m, obs_j;

   assign obs_m = {m_sda, m_slt, m_rcv, m_rfr, m_edc, m_bm, m_esc, m_sbm, m_fd, m_fa, m_tl};
   assign obs_j = {j_sda, j_slt, j_rcv, j_rfr, j_edc, j_bm, j_esc, j_sbm, j_fd, j_fa, j_tl};

   int checks = 0;
   int failures = 0;

   // Current frame description
   int f_kind, f_lt, f_tlen, f_term, f_err;
   logic [2:0] hm_bm, hm_sbm, hj_bm, hj_sbm;

   always #5 clk = ~clk;

   rx_frame_counter dut (
      .rxclk(clk), .reset(reset), .get_sfd(get_sfd), .get_error_code(get_error_code),
      .get_terminate(get_terminate), .lt_data(lt_data), .small_frame(small_frame),
      .tagged_frame(tagged_frame), .tagged_len(tagged_len),
      .start_da(m_sda), .start_lt(m_slt), .receiving(m_rcv), .receiving_frame(m_rfr),
      .end_data_cnt(m_edc), .bits_more(m_bm), .end_small_cnt(m_esc),
      .small_bits_more(m_sbm), .frame_done(m_fd), .frame_abort(m_fa), .too_long(m_tl)
   );

   rx_frame_counter #(.MAX_WORDS(MaxJ)) dut_j (
      .rxclk(clk), .reset(reset), .get_sfd(get_sfd), .get_error_code(get_error_code),
      .get_terminate(get_terminate), .lt_data(lt_data), .small_frame(small_frame),
      .tagged_frame(tagged_frame), .tagged_len(tagged_len),
      .start_da(j_sda), .start_lt(j_slt), .receiving(j_rcv), .receiving_frame(j_rfr),
      .end_data_cnt(j_edc), .bits_more(j_bm), .end_small_cnt(j_esc),
      .small_bits_more(j_sbm), .frame_done(j_fd), .frame_abort(j_fa), .too_long(j_tl)
   );

   function automatic int tag_rem();
      return (f_tlen >= 8) ? f_tlen - 8 : 0;
   endfunction

   // Word index carrying the first FCS byte (length-style frames only)
   function automatic int end_word();
      case (f_kind)
         KLen:    return 3 + f_lt / 8;
         KSmall:  return 3 + Pad / 8;
         KTag:    return 4 + tag_rem() / 8;
         default: return -1;
      endcase
   endfunction

   function automatic logic [2:0] end_bits();
      case (f_kind)
         KLen:    return 3'(f_lt % 8);
         KSmall:  return 3'(Pad % 8);
         default: return 3'(tag_rem() % 8);
      endcase
   endfunction

   function automatic out_t model(input int k, input int mx, input logic [2:0] pbm,
                                  input logic [2:0] psbm);
      out_t e;
      int   endw, dlast, stop, stopk, s, smw;
      bit   lm, found;
      lm    = (f_kind != KType);
      endw  = end_word();
      dlast = lm ? endw : f_term;
      s     = f_lt[15] ? 0 : f_lt;
      smw   = 3 + s / 8;
      stop  = 1 << 20;
      stopk = 0;
      found = 0;
      // First abnormal word: error beats jabber beats early terminate
      for (int w = 1; w <= dlast; w++) begin
         if (!found) begin
            if (w == f_err) begin
               stop = w; stopk = 1; found = 1;
            end else if (w >= 3 && w == mx) begin
               stop = w; stopk = 2; found = 1;
            end else if (lm && w >= 3 && w == f_term && w < endw) begin
               stop = w; stopk = 1; found = 1;
            end
         end
      end
      e     = '0;
      e.sda = (k == 1);
      e.slt = (k == 2) && (stop >= 2);
      e.rcv = (k >= 1) && (k <= ((stopk != 0) ? stop : dlast));
      e.rfr = (k >= 1) && (k <= ((stopk != 0) ? stop : (lm ? endw + 1 : f_term)));
      e.edc = lm && (k == endw) && (endw <= stop);
      e.bm  = (lm && endw <= stop && k >= endw) ? end_bits() : pbm;
      e.esc = (f_kind == KSmall) && (k == smw) && (smw <= stop);
      e.sbm = (f_kind == KSmall && smw <= stop && k >= smw) ? 3'(s % 8) : psbm;
      e.fd  = (stopk == 0) && (k == (lm ? endw + 2 : f_term + 1));
      e.fa  = (stopk == 1) && (k == stop + 1);
      e.tl  = (stopk == 2) && (k == stop + 1);
      return e;
   endfunction

   task automatic cmp(input string tag, input int k, input out_t obs, input out_t exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      get_sfd = 0; get_error_code = 0; get_terminate = 0;
      small_frame = 0; tagged_frame = 0; lt_data = 0; tagged_len = 0;
   endtask

   task automatic set_frame(input int kind, input int lt, input int tlen, input int term,
                            input int err);
      f_kind = kind; f_lt = lt; f_tlen = tlen; f_err = err;
      f_term = (term >= 0) ? term : end_word() + 1;
   endtask

   task automatic run_frame(input string tag, input int rst_at);
      int   last;
      out_t g;
      last = ((f_kind != KType) ? end_word() : f_term) + 2;
      for (int k = 0; k <= last; k++) begin
         @(posedge clk); #1;
         if (k == rst_at) begin
            reset = 1'b1;
            idle_inputs();
            #1;
            cmp({tag, "_rst_main"}, k, obs_m, '0);
            cmp({tag, "_rst_jab"}, k, obs_j, '0);
            @(posedge clk); #1;
            reset = 1'b0;
            hm_bm = 0; hm_sbm = 0; hj_bm = 0; hj_sbm = 0;
            return;
         end
         get_sfd        = (k == 0);
         get_error_code = (k == f_err);
         get_terminate  = (k == f_term);
         lt_data        = 16'(f_lt);
         tagged_len     = 16'(f_tlen);
         small_frame    = (f_kind == KSmall);
         tagged_frame   = (f_kind == KTag);
         @(negedge clk);
         cmp({tag, "_main"}, k, obs_m, model(k, MaxM, hm_bm, hm_sbm));
         cmp({tag, "_jab"}, k, obs_j, model(k, MaxJ, hj_bm, hj_sbm));
      end
      g = model(last, MaxM, hm_bm, hm_sbm);
      hm_bm = g.bm; hm_sbm = g.sbm;
      g = model(last, MaxJ, hj_bm, hj_sbm);
      hj_bm = g.bm; hj_sbm = g.sbm;
      // Spare terminate releases the jabber instance from its drop state
      @(posedge clk); #1;
      idle_inputs();
      get_terminate = 1'b1;
      @(negedge clk);
      g = '0; g.bm = hm_bm; g.sbm = hm_sbm;
      cmp({tag, "_gap_main"}, last + 1, obs_m, g);
      g = '0; g.bm = hj_bm; g.sbm = hj_sbm;
      cmp({tag, "_gap_jab"}, last + 1, obs_j, g);
      @(posedge clk); #1;
      get_terminate = 1'b0;
   endtask

   task automatic random_frame();
      int kind, lt, tlen, term, err, endw, dlast;
      kind = int'($urandom_range(0, 3));
      tlen = 0;
      term = -1;
      case (kind)
         KLen:   lt = int'($urandom_range(0, 120));
         KSmall: lt = ($urandom_range(0, 3) == 0) ? (32'h8000 | int'($urandom_range(0, 255)))
                                                  : int'($urandom_range(0, 45));
         KTag: begin
            lt   = int'($urandom_range(0, 1500));
            tlen = int'($urandom_range(0, 120));
         end
         default: begin
            lt   = int'($urandom_range(16'h05fe, 16'hffff));
            term = int'($urandom_range(3, 20));
         end
      endcase
      set_frame(kind, lt, tlen, term, -1);
      endw = end_word();
      if (kind != KType && endw > 3 && $urandom_range(0, 4) == 0)
         f_term = int'($urandom_range(3, endw - 1));
      dlast = (kind != KType) ? endw : f_term;
      if ($urandom_range(0, 1) == 0) f_err = int'($urandom_range(1, dlast + 2));
      run_frame("rand", -1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "bench did not finish");
   end

   initial begin
      reset = 1'b1;
      idle_inputs();
      hm_bm = 0; hm_sbm = 0; hj_bm = 0; hj_sbm = 0;
      #1;
      cmp("reset_main", 0, obs_m, '0);
      cmp("reset_jab", 0, obs_j, '0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      cmp("post_reset_main", 0, obs_m, '0);
      cmp("post_reset_jab", 0, obs_j, '0);

      set_frame(KLen, 62, 0, -1, -1);
      run_frame("untagged", -1);
      set_frame(KSmall, 14, 0, -1, -1);
      run_frame("small", -1);
      set_frame(KTag, 30, 100, -1, -1);
      run_frame("tagged", -1);
      set_frame(KLen, 62, 0, -1, 5);
      run_frame("error", -1);
      set_frame(KType, 16'h0806, 0, 20, -1);
      run_frame("jabber", -1);
      set_frame(KLen, 62, 0, 5, -1);
      run_frame("early_term", -1);
      set_frame(KSmall, 16'h8003, 0, -1, -1);
      run_frame("small_wrap", -1);
      set_frame(KTag, 0, 5, -1, -1);
      run_frame("tagged_short", -1);
      set_frame(KLen, 62, 0, -1, -1);
      run_frame("reset_mid", 6);
      set_frame(KLen, 62, 0, -1, -1);
      run_frame("after_reset", -1);

      for (int i = 0; i < 40; i++) random_frame();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
